// File: rtl/note_display_scheduler.sv
// Shares one 4-digit 7-segment display among several synth voices.
// A round-robin picker holds each active voice for a dwell period while a scanner multiplexes the digits.
module note_display_scheduler #(
  parameter int NUM_VOICES   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [12*NUM_VOICES-1:0] voice_freq,
  input  logic [NUM_VOICES-1:0]   voice_active,
  output logic [3:0]              anode,
  output logic [6:0]              seg_out,
  output logic [1:0]              cur_voice,
  output logic                    showing
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_SHARP = 7'b0001001;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] rcnt;
  logic [1:0]    digit;
  logic [DW-1:0] dwell, dwell_nx;
  logic [1:0]    cur_nx;
  logic [3:0]    act;
  logic [1:0]    lowest;
  logic [1:0]    rr_next;
  logic          rr_found;
  logic [1:0]    rr_idx;
  logic [11:0]   sel_freq;
  logic [6:0]    letter;
  logic          sharp;
  logic [6:0]    voice_num;
  logic [6:0]    seg_nx;

  // Unused upper request bits read as inactive so they can never be chosen.
  assign act     = 4'(voice_active);
  assign showing = (state == SHOW);

  // Refresh scanner: runs in every state, independent of the voice picker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt  <= '0;
      digit <= 2'd0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt  <= '0;
      digit <= digit + 2'd1;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  // Lowest active voice, and the first active voice after cur_voice in round-robin order.
  always_comb begin
    lowest   = 2'd0;
    rr_next  = cur_voice;
    rr_found = 1'b0;
    rr_idx   = 2'd0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (act[i]) lowest = 2'(i);
    end
    for (int k = NUM_VOICES; k >= 1; k--) begin
      rr_idx = 2'((int'(cur_voice) + k) % NUM_VOICES);
      if (act[rr_idx]) begin
        rr_next  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur_voice;
    dwell_nx = dwell;
    case (state)
      IDLE: begin
        if (|act) begin
          state_nx = SHOW;
          cur_nx   = lowest;
          dwell_nx = '0;
        end
      end
      SHOW: begin
        // A drop coinciding with dwell expiry is a single advance.
        if (!act[cur_voice] || dwell == DW'(DWELL_CYCLES - 1)) begin
          dwell_nx = '0;
          if (rr_found) cur_nx = rr_next;
          else          state_nx = IDLE;
        end else begin
          dwell_nx = dwell + DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_voice <= 2'd0;
      dwell     <= '0;
    end else begin
      state     <= state_nx;
      cur_voice <= cur_nx;
      dwell     <= dwell_nx;
    end
  end

  always_comb begin
    sel_freq = 12'd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (cur_voice == 2'(i)) sel_freq = voice_freq[12*i +: 12];
    end
  end

  always_comb begin
    letter = SEG_DASH;
    sharp  = 1'b0;
    case (sel_freq)
      12'd261: letter = 7'b1000110;
      12'd277: begin letter = 7'b1000110; sharp = 1'b1; end
      12'd293: letter = 7'b0100001;
      12'd311: begin letter = 7'b0100001; sharp = 1'b1; end
      12'd330: letter = 7'b0000110;
      12'd349: letter = 7'b0001110;
      12'd370: begin letter = 7'b0001110; sharp = 1'b1; end
      12'd392: letter = 7'b0010000;
      12'd415: begin letter = 7'b0010000; sharp = 1'b1; end
      12'd440: letter = 7'b0001000;
      12'd466: begin letter = 7'b0001000; sharp = 1'b1; end
      12'd494: letter = 7'b0000011;
      default: begin letter = SEG_DASH; sharp = 1'b0; end
    endcase
  end

  always_comb begin
    case (cur_voice)
      2'd0:    voice_num = 7'b1111001;
      2'd1:    voice_num = 7'b0100100;
      2'd2:    voice_num = 7'b0110000;
      default: voice_num = 7'b0011001;
    endcase
  end

  always_comb begin
    seg_nx = SEG_BLANK;
    if (state == IDLE) begin
      seg_nx = (digit == 2'd0) ? SEG_DASH : SEG_BLANK;
    end else begin
      case (digit)
        2'd0:    seg_nx = letter;
        2'd1:    seg_nx = sharp ? SEG_SHARP : SEG_BLANK;
        2'd2:    seg_nx = SEG_BLANK;
        default: seg_nx = voice_num;
      endcase
    end
  end

  // anode and seg_out share one register stage so the pattern always matches its digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode   <= 4'b1111;
      seg_out <= SEG_BLANK;
    end else begin
      anode   <= ~(4'b0001 << digit);
      seg_out <= seg_nx;
    end
  end

endmodule
